// File: rtl/rf_access_responder.sv
// Responder for the coprocessor register-file bus plus a host preload channel.
// Optional transaction counters are enabled with `define RF_TXN_COUNT_EN.
module rf_access_responder #(
    parameter int size          = 2,
    parameter int cell_width    = 32,
    parameter int address_width = $clog2(size*size)
) (
    input  logic                          in_clk,
    input  logic                          in_reset,
    input  logic                          in_read_en,
    input  logic                          in_write_en,
    input  logic [address_width-1:0]      in_address,
    input  logic [1:0]                    in_type,
    input  logic [1:0]                    in_matrix,
    input  logic [cell_width*size-1:0]    in_data,
    output logic [cell_width*size-1:0]    out_data,
    output logic                          out_data_ready,
    output logic                          out_ack,
    input  logic                          in_host_valid,
    input  logic [address_width-1:0]      in_host_address,
    input  logic [1:0]                    in_host_type,
    input  logic [1:0]                    in_host_matrix,
    input  logic [cell_width*size-1:0]    in_host_data,
    output logic                          out_host_ready,
    output logic [address_width-1:0]      out_rf_address,
    output logic [1:0]                    out_rf_type,
    output logic [1:0]                    out_rf_select_matrix,
    output logic [cell_width*size-1:0]    out_rf_data,
    output logic                          out_rf_read_en,
    output logic                          out_rf_write_en,
    input  logic [cell_width*size-1:0]    in_rf_data,
    output logic                          out_protocol_err
`ifdef RF_TXN_COUNT_EN
    ,
    output logic [15:0]                   out_read_count,
    output logic [15:0]                   out_write_count
`endif
);

    localparam int DataW = cell_width*size;

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_RD_ISSUE   = 3'd1;
    localparam logic [2:0] S_RD_CAPTURE = 3'd2;
    localparam logic [2:0] S_WR_ISSUE   = 3'd3;
    localparam logic [2:0] S_HOST_WR    = 3'd4;
    localparam logic [2:0] S_DONE       = 3'd5;
    localparam logic [2:0] S_RELEASE    = 3'd6;

    logic [2:0]               state_q, state_d;
    logic [address_width-1:0] addr_q, addr_d;
    logic [1:0]               type_q, type_d;
    logic [1:0]               matrix_q, matrix_d;
    logic [DataW-1:0]         wdata_q, wdata_d;
    logic [DataW-1:0]         rdata_q, rdata_d;
    logic                     data_ready_q, data_ready_d;
    logic                     ack_q, ack_d;
    logic                     host_ready_q, host_ready_d;
    logic                     protocol_err_q, protocol_err_d;

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        type_d         = type_q;
        matrix_d       = matrix_q;
        wdata_d        = wdata_q;
        rdata_d        = rdata_q;
        data_ready_d   = 1'b0;
        ack_d          = 1'b0;
        host_ready_d   = 1'b0;
        protocol_err_d = protocol_err_q;

        case (state_q)
            S_IDLE: begin
                if (in_read_en) begin
                    state_d  = S_RD_ISSUE;
                    addr_d   = in_address;
                    type_d   = in_type;
                    matrix_d = in_matrix;
                    wdata_d  = '0;
                    if (in_write_en) begin
                        protocol_err_d = 1'b1;
                    end
                end else if (in_write_en) begin
                    state_d  = S_WR_ISSUE;
                    addr_d   = in_address;
                    type_d   = in_type;
                    matrix_d = in_matrix;
                    wdata_d  = in_data;
                end else if (in_host_valid && !host_ready_q) begin
                    // host_ready_q guard: the host sees ready and drops valid in this same cycle
                    state_d  = S_HOST_WR;
                    addr_d   = in_host_address;
                    type_d   = in_host_type;
                    matrix_d = in_host_matrix;
                    wdata_d  = in_host_data;
                end
            end
            S_RD_ISSUE: state_d = S_RD_CAPTURE;
            S_RD_CAPTURE: begin
                rdata_d      = in_rf_data;
                data_ready_d = 1'b1;
                state_d      = S_RELEASE;
            end
            S_WR_ISSUE: state_d = S_DONE;
            S_DONE: begin
                ack_d   = 1'b1;
                state_d = S_RELEASE;
            end
            S_HOST_WR: begin
                host_ready_d = 1'b1;
                state_d      = S_IDLE;
            end
            S_RELEASE: begin
                if (!in_read_en && !in_write_en) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge in_clk or negedge in_reset) begin
        if (!in_reset) begin
            state_q        <= S_IDLE;
            addr_q         <= '0;
            type_q         <= '0;
            matrix_q       <= '0;
            wdata_q        <= '0;
            rdata_q        <= '0;
            data_ready_q   <= 1'b0;
            ack_q          <= 1'b0;
            host_ready_q   <= 1'b0;
            protocol_err_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            type_q         <= type_d;
            matrix_q       <= matrix_d;
            wdata_q        <= wdata_d;
            rdata_q        <= rdata_d;
            data_ready_q   <= data_ready_d;
            ack_q          <= ack_d;
            host_ready_q   <= host_ready_d;
            protocol_err_q <= protocol_err_d;
        end
    end

    // Enables decode straight from state so an async reset drops them at once.
    logic rf_rd, rf_wr, rf_issue;
    assign rf_rd    = (state_q == S_RD_ISSUE);
    assign rf_wr    = (state_q == S_WR_ISSUE) || (state_q == S_HOST_WR);
    assign rf_issue = rf_rd || rf_wr;

    assign out_rf_read_en       = rf_rd;
    assign out_rf_write_en      = rf_wr;
    assign out_rf_address       = rf_issue ? addr_q   : '0;
    assign out_rf_type          = rf_issue ? type_q   : '0;
    assign out_rf_select_matrix = rf_issue ? matrix_q : '0;
    assign out_rf_data          = rf_wr    ? wdata_q  : '0;

    assign out_data         = rdata_q;
    assign out_data_ready   = data_ready_q;
    assign out_ack          = ack_q;
    assign out_host_ready   = host_ready_q;
    assign out_protocol_err = protocol_err_q;

`ifdef RF_TXN_COUNT_EN
    logic [15:0] rd_cnt_q, rd_cnt_d;
    logic [15:0] wr_cnt_q, wr_cnt_d;

    // Counts advance on the same edge that raises the matching pulse; host writes are excluded.
    always_comb begin
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        if (data_ready_d && (rd_cnt_q != 16'hFFFF)) begin
            rd_cnt_d = rd_cnt_q + 16'd1;
        end
        if (ack_d && (wr_cnt_q != 16'hFFFF)) begin
            wr_cnt_d = wr_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge in_clk or negedge in_reset) begin
        if (!in_reset) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    assign out_read_count  = rd_cnt_q;
    assign out_write_count = wr_cnt_q;
`endif

endmodule
